neuron_layer_sequencer: RTL and testbench

- Upstream feeder/controller for the Neuron block.
- Holds one input vector and the weight sets for NUM_NEURONS neurons.
- On a go command, drives a single shared Neuron instance once per neuron index: start pulse, then in/weight pairs, then wait for ready and capture out.
- Emits one result per neuron index and a done pulse; a layer is evaluated by time-multiplexing one Neuron.

---
 rtl/neuron_layer_sequencer_if.sv | 21 ++
 rtl/neuron_layer_sequencer.sv | 137 +++++++++++++
 tb/tb_neuron_layer_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_layer_sequencer_if.sv
// Link between the layer sequencer and the single shared Neuron it time-multiplexes.
// The master side is the sequencer; the slave side is the Neuron.
interface neuron_layer_sequencer_if;
    logic        nrn_start;
    logic [15:0] nrn_N;
    logic [7:0]  nrn_in;
    logic [7:0]  nrn_weight;
    logic [1:0]  nrn_pass;
    logic [7:0]  nrn_out;
    logic        nrn_ready;

    modport master (
        output nrn_start, nrn_N, nrn_in, nrn_weight, nrn_pass,
        input  nrn_out, nrn_ready
    );

    modport slave (
        input  nrn_start, nrn_N, nrn_in, nrn_weight, nrn_pass,
        output nrn_out, nrn_ready
    );
endinterface

// File: rtl/neuron_layer_sequencer.sv
// Evaluates a layer of NUM_NEURONS neurons by feeding one shared Neuron once per index:
// start pulse, n_cfg input/weight pairs, then a fresh ready handshake to capture its result.
module neuron_layer_sequencer #(
    parameter int MAX_N       = 16,
    parameter int NUM_NEURONS = 4,
    parameter int AW          = 4,
    parameter int NW          = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_wr_en,
    input  logic [AW-1:0] in_wr_addr,
    input  logic [7:0]    in_wr_data,
    input  logic          w_wr_en,
    input  logic [NW-1:0] w_wr_nrn,
    input  logic [AW-1:0] w_wr_addr,
    input  logic [7:0]    w_wr_data,
    input  logic          go,
    input  logic [15:0]   n_cfg,
    input  logic [1:0]    pass_cfg,
    neuron_layer_sequencer_if.master nrn_bus,
    output logic          res_valid,
    output logic [NW-1:0] res_idx,
    output logic [7:0]    res_data,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    typedef enum logic [2:0] {IDLE, START, STREAM, WAIT, STORE, DONE} state_t;

    state_t        state;
    logic [AW-1:0] k;
    logic [AW-1:0] k_nxt;
    logic [NW-1:0] nrn_idx;
    logic          seen_low;

    logic [7:0] inbuf [MAX_N];
    logic [7:0] wmem  [NUM_NEURONS][MAX_N];

    assign k_nxt = k + AW'(1);

    // Buffers are only writable while idle so a pass always streams a consistent snapshot.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE) begin
            if (in_wr_en) inbuf[in_wr_addr] <= in_wr_data;
            if (w_wr_en)  wmem[w_wr_nrn][w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            k                  <= '0;
            nrn_idx            <= '0;
            seen_low           <= 1'b0;
            nrn_bus.nrn_start  <= 1'b0;
            nrn_bus.nrn_N      <= '0;
            nrn_bus.nrn_in     <= '0;
            nrn_bus.nrn_weight <= '0;
            nrn_bus.nrn_pass   <= '0;
            res_valid          <= 1'b0;
            res_idx            <= '0;
            res_data           <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            cfg_err            <= 1'b0;
        end else begin
            nrn_bus.nrn_start <= 1'b0;
            res_valid         <= 1'b0;
            done              <= 1'b0;
            cfg_err           <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        if (n_cfg >= 16'd1 && n_cfg <= 16'(MAX_N)) begin
                            nrn_bus.nrn_N     <= n_cfg;
                            nrn_bus.nrn_pass  <= pass_cfg;
                            nrn_idx           <= '0;
                            nrn_bus.nrn_start <= 1'b1;
                            busy              <= 1'b1;
                            state             <= START;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                // A low ready sampled from START onward proves the Neuron has begun this job.
                START: begin
                    k                  <= '0;
                    seen_low           <= ~nrn_bus.nrn_ready;
                    nrn_bus.nrn_in     <= inbuf[AW'(0)];
                    nrn_bus.nrn_weight <= wmem[nrn_idx][AW'(0)];
                    state              <= STREAM;
                end
                STREAM: begin
                    if (!nrn_bus.nrn_ready) seen_low <= 1'b1;
                    if (16'(k) == nrn_bus.nrn_N - 16'd1) begin
                        nrn_bus.nrn_in     <= '0;
                        nrn_bus.nrn_weight <= '0;
                        state              <= WAIT;
                    end else begin
                        k                  <= k_nxt;
                        nrn_bus.nrn_in     <= inbuf[k_nxt];
                        nrn_bus.nrn_weight <= wmem[nrn_idx][k_nxt];
                    end
                end
                WAIT: begin
                    if (nrn_bus.nrn_ready && seen_low) begin
                        res_data  <= nrn_bus.nrn_out;
                        res_idx   <= nrn_idx;
                        res_valid <= 1'b1;
                        state     <= STORE;
                    end else if (!nrn_bus.nrn_ready) begin
                        seen_low <= 1'b1;
                    end
                end
                STORE: begin
                    if (nrn_idx == NW'(NUM_NEURONS - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        nrn_idx           <= nrn_idx + 1'b1;
                        nrn_bus.nrn_start <= 1'b1;
                        state             <= START;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Bench for neuron_layer_sequencer: a timeline model predicts every output per cycle,
// and a stub Neuron replays ready/out from tables the model plans alongside.
module tb_neuron_layer_sequencer;
    localparam int END = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_wr_en = 1'b0;
    logic [3:0]  in_wr_addr = '0;
    logic [7:0]  in_wr_data = '0;
    logic        w_wr_en = 1'b0;
    logic [1:0]  w_wr_nrn = '0;
    logic [3:0]  w_wr_addr = '0;
    logic [7:0]  w_wr_data = '0;
    logic        go = 1'b0;
    logic [15:0] n_cfg = '0;
    logic [1:0]  pass_cfg = '0;
    logic        res_valid;
    logic [1:0]  res_idx;
    logic [7:0]  res_data;
    logic        busy;
    logic        done;
    logic        cfg_err;

    neuron_layer_sequencer_if nif ();

    neuron_layer_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_wr_en   (in_wr_en),
        .in_wr_addr (in_wr_addr),
        .in_wr_data (in_wr_data),
        .w_wr_en    (w_wr_en),
        .w_wr_nrn   (w_wr_nrn),
        .w_wr_addr  (w_wr_addr),
        .w_wr_data  (w_wr_data),
        .go         (go),
        .n_cfg      (n_cfg),
        .pass_cfg   (pass_cfg),
        .nrn_bus    (nif),
        .res_valid  (res_valid),
        .res_idx    (res_idx),
        .res_data   (res_data),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total = 0;
    bit checking = 1'b0;

    // Expected output timeline and stub-Neuron tables, one entry per cycle.
    logic        exp_start [END];
    logic [15:0] exp_N     [END];
    logic [7:0]  exp_in    [END];
    logic [7:0]  exp_w     [END];
    logic [1:0]  exp_pass  [END];
    logic        exp_rv    [END];
    logic [1:0]  exp_idx   [END];
    logic [7:0]  exp_data  [END];
    logic        exp_busy  [END];
    logic        exp_done  [END];
    logic        exp_err   [END];
    logic        ready_tab [END];
    logic [7:0]  out_tab   [END];

    logic [7:0] in_m [16];
    logic [7:0] w_m  [4][16];

    initial begin
        for (int c = 0; c < END; c++) begin
            exp_start[c] = 0; exp_N[c] = 0; exp_in[c] = 0; exp_w[c] = 0;
            exp_pass[c] = 0; exp_rv[c] = 0; exp_idx[c] = 0; exp_data[c] = 0;
            exp_busy[c] = 0; exp_done[c] = 0; exp_err[c] = 0;
            ready_tab[c] = 1; out_tab[c] = 0;
        end
        for (int k = 0; k < 16; k++) begin
            in_m[k] = 0;
            for (int n = 0; n < 4; n++) w_m[n][k] = 0;
        end
        nif.nrn_ready = 1'b1;
        nif.nrn_out   = 8'h00;
    end

    always @(posedge clk) begin
        #1;
        if (cyc < END) begin
            nif.nrn_ready = ready_tab[cyc];
            nif.nrn_out   = out_tab[cyc];
        end
    end

    logic [48:0] act, want;
    always @(posedge clk) begin
        #1;
        if (checking && cyc < END) begin
            act  = {nif.nrn_start, nif.nrn_N, nif.nrn_in, nif.nrn_weight, nif.nrn_pass,
                    res_valid, res_idx, res_data, busy, done, cfg_err};
            want = {exp_start[cyc], exp_N[cyc], exp_in[cyc], exp_w[cyc], exp_pass[cyc],
                    exp_rv[cyc], exp_idx[cyc], exp_data[cyc], exp_busy[cyc], exp_done[cyc],
                    exp_err[cyc]};
            total++;
            if (act === want) passed++;
            else $display("[TB] FAIL cycle%0d outputs: got %h expected %h", cyc, act, want);
        end
    end

    initial begin
        #60000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) tick();
    endtask

    task automatic waitIdleModel();
        while (cyc < END - 1 && exp_busy[cyc]) tick();
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    // Plans a go issued in cycle g: start one cycle later, n pairs, capture on the first
    // high ready preceded by a low since start, result the cycle after, next neuron after that.
    task automatic planGo(input int g, input int n, input logic [1:0] p, input int lo_off, input int lo_len);
        int s, t, sum;
        logic [7:0] acc;
        bit low;
        if (exp_busy[g]) return;
        if (n < 1 || n > 16) begin
            exp_err[g+1] = 1;
            return;
        end
        for (int c = g + 1; c < END; c++) begin
            exp_N[c] = 16'(n);
            exp_pass[c] = p;
        end
        s = g + 1;
        for (int nr = 0; nr < 4; nr++) begin
            for (int c = s + lo_off; c < s + lo_off + lo_len; c++) ready_tab[c] = 0;
            sum = 0;
            for (int k = 0; k < n; k++) sum += int'(in_m[k]) * int'(w_m[nr][k]);
            acc = 8'(sum);
            exp_start[s] = 1;
            for (int k = 0; k < n; k++) begin
                exp_in[s+1+k] = in_m[k];
                exp_w[s+1+k]  = w_m[nr][k];
            end
            t = s + 1 + n;
            while (t < s + 200) begin
                low = 0;
                for (int c = s; c < t; c++) if (!ready_tab[c]) low = 1;
                if (ready_tab[t] && low) break;
                t++;
            end
            for (int c = s; c <= t; c++) out_tab[c] = acc;
            for (int c = s; c <= t + 1; c++) exp_busy[c] = 1;
            exp_rv[t+1] = 1;
            for (int c = t + 1; c < END; c++) begin
                exp_idx[c]  = 2'(nr);
                exp_data[c] = acc;
            end
            s = t + 2;
        end
        exp_done[s] = 1;
        exp_busy[s] = 1;
    endtask

    task automatic resetAt(input int r);
        for (int c = r + 1; c < END; c++) begin
            exp_start[c] = 0; exp_N[c] = 0; exp_in[c] = 0; exp_w[c] = 0;
            exp_pass[c] = 0; exp_rv[c] = 0; exp_idx[c] = 0; exp_data[c] = 0;
            exp_busy[c] = 0; exp_done[c] = 0; exp_err[c] = 0;
            ready_tab[c] = 1;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] n, input logic [1:0] p, input int lo_off, input int lo_len);
        go = 1'b1;
        n_cfg = n;
        pass_cfg = p;
        planGo(cyc, int'(n), p, lo_off, lo_len);
        tick();
        go = 1'b0;
    endtask

    task automatic writeMem(input logic ie, input logic [3:0] ia, input logic [7:0] id,
                            input logic we, input logic [1:0] wn, input logic [3:0] wa, input logic [7:0] wd);
        in_wr_en = ie; in_wr_addr = ia; in_wr_data = id;
        w_wr_en = we; w_wr_nrn = wn; w_wr_addr = wa; w_wr_data = wd;
        if (!exp_busy[cyc]) begin
            if (ie) in_m[ia] = id;
            if (we) w_m[wn][wa] = wd;
        end
        tick();
        in_wr_en = 1'b0;
        w_wr_en = 1'b0;
    endtask

    int g;
    logic [7:0] wval [4];

    initial begin
        wval[0] = 8'd2; wval[1] = 8'd1; wval[2] = 8'd3; wval[3] = 8'd5;
        tick();
        checking = 1'b1;
        tick();
        checkOutput("reset", {nif.nrn_start, nif.nrn_N, nif.nrn_in, nif.nrn_weight, nif.nrn_pass,
                              res_valid, res_idx, res_data, busy, done, cfg_err}, 64'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 16; k++) writeMem(1'b1, 4'(k), 8'(k + 1), 1'b1, 2'd0, 4'(k), wval[0]);
        for (int n = 1; n < 4; n++)
            for (int k = 0; k < 16; k++) writeMem(1'b0, 4'd0, 8'd0, 1'b1, 2'(n), 4'(k), wval[n]);

        // Full four-neuron pass with n=4; every neuron drops ready for three cycles.
        g = cyc;
        applyStimulus(16'd4, 2'd2, 1, 3);
        checkOutput("t1_start", {nif.nrn_start, nif.nrn_N, nif.nrn_pass}, {1'b1, 16'd4, 2'd2});
        for (int k = 0; k < 4; k++) begin
            waitUntil(g + 2 + k);
            checkOutput("t1_pair", {nif.nrn_in, nif.nrn_weight}, {8'(k + 1), 8'd2});
        end
        waitUntil(g + 7);
        checkOutput("t1_res0", {res_valid, res_idx, res_data}, {1'b1, 2'd0, 8'h14});
        waitUntil(g + 14);
        checkOutput("t2_res1", {res_valid, res_idx, res_data}, {1'b1, 2'd1, 8'h0A});
        waitUntil(g + 21);
        checkOutput("t2_res2", {res_valid, res_idx, res_data}, {1'b1, 2'd2, 8'h1E});
        waitUntil(g + 28);
        checkOutput("t2_res3", {res_valid, res_idx, res_data}, {1'b1, 2'd3, 8'h32});
        waitUntil(g + 29);
        checkOutput("t2_done", {done, busy, res_valid}, 3'b110);
        waitUntil(g + 30);
        checkOutput("t2_idle", {done, busy, res_valid}, 3'b000);
        tick();

        // Out-of-range n_cfg values are rejected.
        applyStimulus(16'd0, 2'd0, 1, 1);
        checkOutput("t3_err0", {cfg_err, busy, nif.nrn_start}, 3'b100);
        applyStimulus(16'd17, 2'd0, 1, 1);
        checkOutput("t3_err17", {cfg_err, busy, nif.nrn_start}, 3'b100);
        tick();

        // n_cfg at the MAX_N boundary.
        g = cyc;
        applyStimulus(16'd16, 2'd1, 1, 2);
        waitUntil(g + 19);
        checkOutput("t3_max_res0", {res_valid, res_idx, res_data}, {1'b1, 2'd0, 8'h10});
        waitIdleModel();

        // Stale high ready in WAIT must not be taken; capture follows the later low.
        g = cyc;
        applyStimulus(16'd1, 2'd0, 3, 2);
        waitUntil(g + 4);
        checkOutput("t4_no_stale", {res_valid}, 1'b0);
        waitUntil(g + 7);
        checkOutput("t4_capture", {res_valid, res_idx, res_data}, {1'b1, 2'd0, 8'h02});
        waitIdleModel();

        // Reset mid-stream aborts the pass; memories survive.
        g = cyc;
        applyStimulus(16'd4, 2'd1, 1, 3);
        waitUntil(g + 4);
        checkOutput("t5_pair2", {nif.nrn_in, nif.nrn_weight}, {8'd3, 8'd2});
        rst = 1'b1;
        resetAt(cyc);
        tick();
        rst = 1'b0;
        checkOutput("t5_abort", {nif.nrn_start, nif.nrn_N, nif.nrn_in, nif.nrn_weight, nif.nrn_pass,
                                 res_valid, res_idx, res_data, busy, done, cfg_err}, 64'd0);
        tick();
        g = cyc;
        applyStimulus(16'd1, 2'd0, 1, 1);
        waitUntil(g + 4);
        checkOutput("t5_after", {res_valid, res_idx, res_data}, {1'b1, 2'd0, 8'h02});
        waitIdleModel();

        // Writes and go while busy are dropped.
        applyStimulus(16'd2, 2'd3, 1, 1);
        writeMem(1'b1, 4'd0, 8'h77, 1'b1, 2'd0, 4'd0, 8'h55);
        applyStimulus(16'd3, 2'd0, 1, 1);
        waitIdleModel();
        g = cyc;
        applyStimulus(16'd2, 2'd0, 1, 1);
        waitUntil(g + 2);
        checkOutput("t6_old_pair", {nif.nrn_in, nif.nrn_weight}, {8'd1, 8'd2});
        waitUntil(g + 5);
        checkOutput("t6_old_res", {res_valid, res_idx, res_data}, {1'b1, 2'd0, 8'h06});
        waitIdleModel();
        tick();
        tick();

        checking = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
